spi_bus_arbiter: RTL

Shares one byte-wide SPI transaction engine (8-bit addr/wdata, read flag, `enable` pulse, `done` level) between two client state machines, e.g. the IMU poller and a second sensor's configuration sequencer. Round-robin arbitration picks a client and sequences the engine: latch command, pulse enable, wait for done. It then returns the result to the winner and enforces a minimum idle gap on the bus before the next grant.

---
 rtl/spi_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI transaction engine between two clients.
// Optional BUSY watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       read0,
  input  logic       read1,
  output logic [1:0] grant,
  output logic [1:0] cli_done,
  output logic [7:0] cli_rdata,
  output logic       cli_err,
  output logic       eng_enable,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_wdata,
  output logic       eng_read,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  output logic [1:0] dbg_state
);

  // Handshake: a client raises req[i] with a stable command and holds both until
  // cli_done[i] pulses; the arbiter only samples req in IDLE, so a dropped req
  // after the grant still completes and re-requests are seen after the idle gap.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("spi_bus_arbiter: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  state_t        state;
  logic          last;
  logic          done_q;
  logic [GW-1:0] gap_cnt;
  logic          done_rise;
  logic          win;

  assign done_rise = eng_done & ~done_q;
  assign dbg_state = state;

  // Winner index: a lone requester wins; a tie goes to the client that was not last.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10) win = 1'b1;
    else if (req == 2'b11) win = ~last;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] busy_cnt;
`else
  assign cli_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      done_q     <= 1'b0;
      gap_cnt    <= '0;
      grant      <= 2'b00;
      cli_done   <= 2'b00;
      cli_rdata  <= 8'h00;
      eng_enable <= 1'b0;
      eng_addr   <= 8'h00;
      eng_wdata  <= 8'h00;
      eng_read   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cli_err    <= 1'b0;
      busy_cnt   <= '0;
`endif
    end else begin
      done_q     <= eng_done;
      eng_enable <= 1'b0;
      cli_done   <= 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
      cli_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            last       <= win;
            grant      <= win ? 2'b10 : 2'b01;
            eng_addr   <= win ? addr1 : addr0;
            eng_wdata  <= win ? wdata1 : wdata0;
            eng_read   <= win ? read1 : read0;
            eng_enable <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
          busy_cnt <= '0;
`endif
        end
        BUSY: begin
          // Only a fresh low-to-high edge completes; a done level left high is ignored.
          if (done_rise) begin
            cli_rdata <= eng_rdata;
            cli_done  <= grant;
            grant     <= 2'b00;
            gap_cnt   <= '0;
            state     <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (busy_cnt == TMO_LAST) begin
            cli_rdata <= 8'hFF;
            cli_done  <= grant;
            cli_err   <= 1'b1;
            grant     <= 2'b00;
            gap_cnt   <= '0;
            state     <= GAP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
